serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around a single full-adder cell with a registered carry. It sits directly downstream of the one-bit full adder and reuses that cell once per clock, LSB first, to add two WIDTH-bit operands. The block trades throughput for area and is the multi-bit consumer of the full-adder stage. A start/busy/done handshake frames each operation.

## Interface
- WIDTH, 8, operand and sum width in bits; must be >= 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cin  in  1  carry-in; captured on the accepting edge.
- sub  in  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- busy  out  1  high while in the SHIFT state.
- done  out  1  high for exactly one cycle, in the DONE state.
- sum  out  WIDTH  result of the last completed operation.
- cout  out  1  carry-out of the last completed operation.

## Operation
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE with start=1:
  - load a_sr=a, b_sr=b, carry=cin, cnt=0.
  - go to SHIFT.
- SHIFT, each edge:
  - full-add a_sr[0], b_sr[0] and carry.
  - shift the sum bit into the MSB of sum_sr; shift sum_sr, a_sr and b_sr right by 1.
  - carry <= carry-out; cnt <= cnt+1.
- SHIFT, edge with cnt==WIDTH-1:
  - sum <= final sum_sr value; cout <= final carry.
  - go to DONE.
- DONE:
  - start=1 accepts a new operation exactly as in IDLE; go to SHIFT.
  - otherwise go to IDLE.
- start is ignored in SHIFT; the operation in flight is unaffected.
- sum and cout change only on the completion edge and hold otherwise. Internal shift registers are not visible on outputs.
- Arithmetic is modulo 2^WIDTH, with cout the bit-WIDTH carry. Counter width is $clog2(WIDTH).
- Reset values:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - all internal registers 0.
- Reset asserted mid-operation aborts immediately; no done pulse follows.
- Operand changes after the accepting edge have no effect.

## Timing
- Accepting edge T0: busy=1 after T0.
- Shift edges T1..TWIDTH. On TWIDTH: sum/cout valid, done=1, busy=0.
- TWIDTH+1: done=0.
- Latency from accepting edge to done: WIDTH edges.
- Back-to-back throughput: one result per WIDTH+1 cycles when start is held high.
- busy and done are never high in the same cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the sub port exists.
  - with sub=1 on the accepting edge: b_sr loads ~b and carry loads 1; cin is ignored.
  - result is a-b mod 2^WIDTH; cout=1 means no borrow.
  - with sub=0, behaviour is identical to addition.
- Undefined: no sub port; addition only.

## Test plan
- WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulse -> done high 8 edges after the accepting edge; sum=8'h00, cout=1.
- a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0. busy high for exactly 8 cycles; done high for exactly 1 cycle.
- start re-pulsed with a=8'h01, b=8'h01 at T3 of an operation of 8'h5A+8'h3C (cin=1) -> ignored; result 8'h97.
- rst asserted after T4 of an operation -> busy=0, done=0, sum=0, cout=0 immediately; no done pulse follows.
- start held high across two operations, 8'h10+8'h20 then 8'h7F+8'h01 -> sum 8'h30 on the first done, then 8'h80 on the second done; done pulses 9 cycles apart.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, 8'h10-8'h01 -> sum=8'h0F, cout=1.
  - sub=1, 8'h00-8'h01 -> sum=8'hFF, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused per clock, LSB first, with a registered carry.
// Define SERIAL_ADDER_SUB_EN to add the i_sub port for two's-complement subtraction.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_sum_sr;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;

  logic               w_fa_sum;
  logic               w_fa_cout;
  logic [WIDTH-1:0]   w_sum_sr_nxt;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_carry_load;

  // Single full-adder cell on the LSBs of the operand shift registers
  assign w_fa_sum     = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_fa_cout    = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));
  assign w_sum_sr_nxt = {w_fa_sum, r_sum_sr[WIDTH-1:1]};
  assign w_last       = (r_state == S_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; cin is ignored in that mode
  assign w_b_load     = i_sub ? ~i_b : i_b;
  assign w_carry_load = i_sub ? 1'b1 : i_cin;
`else
  assign w_b_load     = i_b;
  assign w_carry_load = i_cin;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_SHIFT);
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a_sr  <= i_a;
        r_b_sr  <= w_b_load;
        r_carry <= w_carry_load;
        r_cnt   <= '0;
      end else if (r_state == S_SHIFT) begin
        r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
        r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
        r_sum_sr <= w_sum_sr_nxt;
        r_carry  <= w_fa_cout;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_sum  <= w_sum_sr_nxt;
          r_cout <= w_fa_cout;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table of single operations plus hand-written
// sequences for start-while-busy, mid-operation reset and back-to-back operation.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
    string      name;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] prev_s = 8'h00;
  logic       prev_c = 1'b0;
  vec_t       vecs[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub   (sub),
`endif
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Advance negedges until done, starting from edge count e; bounded.
  task automatic wait_done(inout int e, inout int busy_n);
    while (done !== 1'b1 && e <= int'(WIDTH) + 4) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      e++;
    end
  endtask

  task automatic run_op(input vec_t v);
    int e      = 0;
    int busy_n = 0;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = ~cin; sub = ~sub;
    chk({v.name, "_sum_hold"}, 32'(sum), 32'(prev_s));
    wait_done(e, busy_n);
    chk({v.name, "_latency"}, 32'(e), 32'(WIDTH));
    chk({v.name, "_busy_cycles"}, 32'(busy_n), 32'(WIDTH));
    chk({v.name, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({v.name, "_sum"}, 32'(sum), 32'(v.s));
    chk({v.name, "_cout"}, 32'(cout), 32'(v.c));
    prev_s = v.s; prev_c = v.c;
    @(negedge clk);
    chk({v.name, "_done_1cyc"}, 32'(done), 32'd0);
    chk({v.name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int e;
    int busy_n;
    int seen;

    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "ff_p_01"});
    vecs.push_back('{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, "5a_p_3c_c1"});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, "80_p_80"});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "ff_p_ff_c1"});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, "00_p_00_c1"});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, "12_p_34"});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "10_m_01"});
    vecs.push_back('{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, "00_m_01"});
    vecs.push_back('{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, "55_m_55"});
    vecs.push_back('{8'h34, 8'h12, 1'b0, 1'b0, 8'h46, 1'b0, "34_p_12_sub0"});
`endif

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // start re-pulsed at T3 must not disturb the operation in flight
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    e = 3; busy_n = 0;
    wait_done(e, busy_n);
    chk("ign_latency", 32'(e), 32'(WIDTH));
    chk("ign_sum", 32'(sum), 32'h97);
    chk("ign_cout", 32'(cout), 32'd0);
    @(negedge clk);
    chk("ign_no_restart", 32'(busy), 32'd0);

    // reset after T4 aborts immediately with no done pulse afterwards
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < int'(WIDTH) + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // start held high: two operations, done pulses WIDTH+1 cycles apart
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h7F; b = 8'h01;
    e = 0; busy_n = 0;
    wait_done(e, busy_n);
    chk("b2b_lat1", 32'(e), 32'(WIDTH));
    chk("b2b_sum1", 32'(sum), 32'h30);
    chk("b2b_cout1", 32'(cout), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_again", 32'(busy), 32'd1);
    chk("b2b_done_drop", 32'(done), 32'd0);
    e = 1; busy_n = 0;
    wait_done(e, busy_n);
    chk("b2b_gap", 32'(e), 32'(WIDTH + 1));
    chk("b2b_sum2", 32'(sum), 32'h80);
    chk("b2b_cout2", 32'(cout), 32'd0);
    @(negedge clk);
    chk("b2b_done_1cyc", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
